// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// FSM encoding, parameter defaults and the source/destination match helper.
package hazard_pkg;

    localparam int DATA_W_DEF           = 32;
    localparam int MDU_CYCLES_DEF       = 32;
    localparam int EXC_FLUSH_CYCLES_DEF = 1;

    // Stage positions inside the per-stage flush vector.
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_t;

    // A used, non-zero source register that a writing instruction targets.
    function automatic logic src_hit(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic       wen,
                                     input logic [4:0] dst);
        return use_src && (src != REG_ZERO) && wen && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One ID-stage source operand: matches it against EX/MEM destinations and
// selects the youngest non-load producer. Raw hits go back to the top for
// stall detection.
module hazard_ctrl_fwd_sel
    import hazard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_use,
    input  logic [4:0]        i_idx,
    input  logic              i_ex_wen,
    input  logic [4:0]        i_ex_rd,
    input  logic              i_ex_is_load,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic              i_mem_wen,
    input  logic [4:0]        i_mem_rd,
    input  logic              i_mem_is_load,
    input  logic [DATA_W-1:0] i_mem_result,
    output logic              o_fwd_valid,
    output logic [DATA_W-1:0] o_fwd_data,
    output logic              o_ex_hit,
    output logic              o_mem_hit
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = src_hit(i_use, i_idx, i_ex_wen,  i_ex_rd);
    assign w_mem_hit = src_hit(i_use, i_idx, i_mem_wen, i_mem_rd);

    assign o_ex_hit  = w_ex_hit;
    assign o_mem_hit = w_mem_hit;

    // EX is younger than MEM, so it wins; load results are not yet available.
    always_comb begin
        o_fwd_valid = 1'b0;
        o_fwd_data  = '0;
        if (w_ex_hit && !i_ex_is_load) begin
            o_fwd_valid = 1'b1;
            o_fwd_data  = i_ex_result;
        end else if (w_mem_hit && !i_mem_is_load) begin
            o_fwd_valid = 1'b1;
            o_fwd_data  = i_mem_result;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler: ID-stage forwarding, load-use / branch-after-load /
// MDU-busy stalls, and exception/eret flush sequencing.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal operation, stalls honoured
//   ST_FLUSH | younger stages held flushed for EXC_FLUSH_CYCLES cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W           = DATA_W_DEF,
    parameter int MDU_CYCLES       = MDU_CYCLES_DEF,
    parameter int EXC_FLUSH_CYCLES = EXC_FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_mdu_use,
    input  logic              ex_wen,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_mdu_start,
    input  logic              mem_wen,
    input  logic [4:0]        mem_rd,
    input  logic              mem_is_load,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              exc_req,
    output logic              if_id_ready,
    output logic              ex_ready,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              s_rs_fastforward,
    output logic [DATA_W-1:0] d_rs_fastforward,
    output logic              s_rt_fastforward,
    output logic [DATA_W-1:0] d_rt_fastforward,
    output logic              mdu_busy
);

    localparam int                MDU_CW   = $clog2(MDU_CYCLES);
    localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_CYCLES - 1);
    localparam int                FL_CW    = (EXC_FLUSH_CYCLES > 1) ? $clog2(EXC_FLUSH_CYCLES) : 1;
    localparam logic [FL_CW-1:0]  FL_LOAD  = FL_CW'(EXC_FLUSH_CYCLES - 1);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [FL_CW-1:0]  r_flush_cnt;
    logic [FL_CW-1:0]  w_flush_cnt_nxt;
    logic [MDU_CW-1:0] r_mdu_cnt;

    logic              w_rs_valid, w_rt_valid;
    logic [DATA_W-1:0] w_rs_data,  w_rt_data;
    logic              w_rs_ex_hit, w_rs_mem_hit, w_rt_ex_hit, w_rt_mem_hit;
    logic              w_load_use, w_br_load, w_mdu_stall, w_stall;
    logic              w_mdu_busy, w_flushing, w_if_id_ready, w_ex_ready;
    logic [STG_MEM:STG_ID] w_flush_vec;

    hazard_ctrl_fwd_sel #(.DATA_W(DATA_W)) u_fwd_rs (
        .i_use         (id_use_rs),
        .i_idx         (id_rs),
        .i_ex_wen      (ex_wen),
        .i_ex_rd       (ex_rd),
        .i_ex_is_load  (ex_is_load),
        .i_ex_result   (ex_result),
        .i_mem_wen     (mem_wen),
        .i_mem_rd      (mem_rd),
        .i_mem_is_load (mem_is_load),
        .i_mem_result  (mem_result),
        .o_fwd_valid   (w_rs_valid),
        .o_fwd_data    (w_rs_data),
        .o_ex_hit      (w_rs_ex_hit),
        .o_mem_hit     (w_rs_mem_hit)
    );

    hazard_ctrl_fwd_sel #(.DATA_W(DATA_W)) u_fwd_rt (
        .i_use         (id_use_rt),
        .i_idx         (id_rt),
        .i_ex_wen      (ex_wen),
        .i_ex_rd       (ex_rd),
        .i_ex_is_load  (ex_is_load),
        .i_ex_result   (ex_result),
        .i_mem_wen     (mem_wen),
        .i_mem_rd      (mem_rd),
        .i_mem_is_load (mem_is_load),
        .i_mem_result  (mem_result),
        .o_fwd_valid   (w_rt_valid),
        .o_fwd_data    (w_rt_data),
        .o_ex_hit      (w_rt_ex_hit),
        .o_mem_hit     (w_rt_mem_hit)
    );

    // A branch needing an EX load result is already caught by load-use.
    assign w_load_use  = ex_is_load && (w_rs_ex_hit || w_rt_ex_hit);
    assign w_br_load   = id_is_branch && mem_is_load && (w_rs_mem_hit || w_rt_mem_hit);
    assign w_mdu_busy  = (r_mdu_cnt != '0);
    assign w_mdu_stall = id_mdu_use && w_mdu_busy;
    assign w_stall     = w_load_use || w_br_load || w_mdu_stall;

    // State and flush-hold counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next state plus ready/flush strobes; exceptions override any stall.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_flushing      = 1'b0;
        w_if_id_ready   = 1'b1;
        w_ex_ready      = 1'b1;
        w_flush_vec     = '0;

        if (exc_req) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FL_LOAD;
            w_flushing      = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            w_flushing = 1'b1;
            if (r_flush_cnt == '0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_flush_cnt_nxt = r_flush_cnt - 1'b1;
            end
        end

        // Outputs stay at their idle values while reset is held.
        if (rst_n) begin
            if (w_flushing) begin
                w_flush_vec = '1;
            end else if (w_stall) begin
                w_if_id_ready        = 1'b0;
                w_flush_vec[STG_EX]  = 1'b1;
            end
        end
    end

    // MDU occupancy down-counter; a new start always reloads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (ex_mdu_start && w_ex_ready) begin
            r_mdu_cnt <= MDU_LOAD;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end
    end

    assign if_id_ready      = w_if_id_ready;
    assign ex_ready         = w_ex_ready;
    assign id_flush         = w_flush_vec[STG_ID];
    assign ex_flush         = w_flush_vec[STG_EX];
    assign mem_flush        = w_flush_vec[STG_MEM];
    assign s_rs_fastforward = rst_n && w_rs_valid;
    assign d_rs_fastforward = rst_n ? w_rs_data : '0;
    assign s_rt_fastforward = rst_n && w_rt_valid;
    assign d_rt_fastforward = rst_n ? w_rt_data : '0;
    assign mdu_busy         = rst_n && w_mdu_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MDU_CYCLES=4, EXC_FLUSH_CYCLES=1).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt, id_is_branch, id_mdu_use;
    logic        ex_wen, ex_is_load, ex_mdu_start;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        mem_wen, mem_is_load;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        exc_req;
    logic        if_id_ready, ex_ready, id_flush, ex_flush, mem_flush;
    logic        s_rs_fastforward, s_rt_fastforward, mdu_busy;
    logic [31:0] d_rs_fastforward, d_rt_fastforward;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DATA_W(32), .MDU_CYCLES(4), .EXC_FLUSH_CYCLES(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_use_rs        (id_use_rs),
        .id_use_rt        (id_use_rt),
        .id_is_branch     (id_is_branch),
        .id_mdu_use       (id_mdu_use),
        .ex_wen           (ex_wen),
        .ex_rd            (ex_rd),
        .ex_is_load       (ex_is_load),
        .ex_result        (ex_result),
        .ex_mdu_start     (ex_mdu_start),
        .mem_wen          (mem_wen),
        .mem_rd           (mem_rd),
        .mem_is_load      (mem_is_load),
        .mem_result       (mem_result),
        .exc_req          (exc_req),
        .if_id_ready      (if_id_ready),
        .ex_ready         (ex_ready),
        .id_flush         (id_flush),
        .ex_flush         (ex_flush),
        .mem_flush        (mem_flush),
        .s_rs_fastforward (s_rs_fastforward),
        .d_rs_fastforward (d_rs_fastforward),
        .s_rt_fastforward (s_rt_fastforward),
        .d_rt_fastforward (d_rt_fastforward),
        .mdu_busy         (mdu_busy)
    );

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_branch = 0; id_mdu_use = 0;
        ex_wen = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0; ex_mdu_start = 0;
        mem_wen = 0; mem_rd = 0; mem_is_load = 0; mem_result = 0;
        exc_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        // hazard-producing inputs while reset held: outputs must stay idle
        id_rs = 5; id_use_rs = 1; ex_wen = 1; ex_rd = 5; ex_is_load = 1; ex_result = 32'hDEAD;
        #1;
        n_checks++; if (if_id_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ready: got %b want 1", if_id_ready); end
        n_checks++; if (ex_flush !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ex_flush: got %b want 0", ex_flush); end
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        n_checks++; if ({if_id_ready, ex_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_ready: got %b want 11", {if_id_ready, ex_ready}); end
        n_checks++; if ({id_flush, ex_flush, mem_flush} !== 3'b000) begin n_fail++; $display("FAIL rst_flush: got %b want 000", {id_flush, ex_flush, mem_flush}); end
        n_checks++; if ({s_rs_fastforward, s_rt_fastforward, mdu_busy} !== 3'b000) begin n_fail++; $display("FAIL rst_fwd_busy: got %b want 000", {s_rs_fastforward, s_rt_fastforward, mdu_busy}); end
    endtask

    task automatic test_forward();
        tick();
        idle();
        id_rs = 5; id_use_rs = 1; id_is_branch = 1;
        ex_wen = 1; ex_rd = 5; ex_result = 32'h1234;
        #1;
        n_checks++; if (s_rs_fastforward !== 1'b1 || d_rs_fastforward !== 32'h1234) begin n_fail++; $display("FAIL fwd_ex_rs: got %b/%h want 1/00001234", s_rs_fastforward, d_rs_fastforward); end
        n_checks++; if (if_id_ready !== 1'b1 || ex_flush !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_nostall: got %b%b want 10", if_id_ready, ex_flush); end
        mem_wen = 1; mem_rd = 5; mem_result = 32'hBEEF;
        #1;
        n_checks++; if (d_rs_fastforward !== 32'h1234) begin n_fail++; $display("FAIL fwd_ex_priority: got %h want 00001234", d_rs_fastforward); end
        ex_wen = 0;
        id_rt = 7; id_use_rt = 1; mem_rd = 7;
        #1;
        n_checks++; if (s_rs_fastforward !== 1'b0 || d_rs_fastforward !== 32'h0) begin n_fail++; $display("FAIL fwd_rs_none: got %b/%h want 0/00000000", s_rs_fastforward, d_rs_fastforward); end
        n_checks++; if (s_rt_fastforward !== 1'b1 || d_rt_fastforward !== 32'hBEEF) begin n_fail++; $display("FAIL fwd_mem_rt: got %b/%h want 1/0000beef", s_rt_fastforward, d_rt_fastforward); end
    endtask

    task automatic test_load_use();
        tick();
        idle();
        id_rt = 8; id_use_rt = 1;
        ex_wen = 1; ex_rd = 8; ex_is_load = 1; ex_result = 32'h55;
        #1;
        n_checks++; if ({if_id_ready, ex_ready, ex_flush, id_flush} !== 4'b0110) begin n_fail++; $display("FAIL load_use_stall: got %b want 0110", {if_id_ready, ex_ready, ex_flush, id_flush}); end
        n_checks++; if (s_rt_fastforward !== 1'b0) begin n_fail++; $display("FAIL load_use_nofwd: got %b want 0", s_rt_fastforward); end
        tick();
        // bubble in EX, load moved to MEM; non-branch consumer does not stall
        ex_wen = 0; ex_is_load = 0; ex_rd = 0;
        mem_wen = 1; mem_rd = 8; mem_is_load = 1;
        #1;
        n_checks++; if ({if_id_ready, ex_flush} !== 2'b10) begin n_fail++; $display("FAIL load_use_clear: got %b want 10", {if_id_ready, ex_flush}); end
    endtask

    task automatic test_branch_load();
        tick();
        idle();
        id_rs = 3; id_use_rs = 1; id_is_branch = 1;
        mem_wen = 1; mem_rd = 3; mem_is_load = 1;
        #1;
        n_checks++; if ({if_id_ready, ex_flush, mem_flush} !== 3'b010) begin n_fail++; $display("FAIL br_load_stall: got %b want 010", {if_id_ready, ex_flush, mem_flush}); end
        tick();
        mem_wen = 0; mem_is_load = 0; mem_rd = 0;
        #1;
        n_checks++; if ({if_id_ready, ex_flush} !== 2'b10) begin n_fail++; $display("FAIL br_load_clear: got %b want 10", {if_id_ready, ex_flush}); end
        // r0 source never matches
        id_rs = 0; ex_wen = 1; ex_rd = 0; ex_is_load = 1;
        #1;
        n_checks++; if ({if_id_ready, s_rs_fastforward} !== 2'b10) begin n_fail++; $display("FAIL r0_load: got %b want 10", {if_id_ready, s_rs_fastforward}); end
        ex_is_load = 0; ex_result = 32'h77;
        #1;
        n_checks++; if (s_rs_fastforward !== 1'b0 || d_rs_fastforward !== 32'h0) begin n_fail++; $display("FAIL r0_fwd: got %b/%h want 0/00000000", s_rs_fastforward, d_rs_fastforward); end
    endtask

    task automatic test_mdu();
        tick();
        idle();
        ex_mdu_start = 1;
        #1;
        n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_start_same: got %b want 0", mdu_busy); end
        tick();
        ex_mdu_start = 0; id_mdu_use = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({mdu_busy, if_id_ready, ex_flush} !== 3'b101) begin n_fail++; $display("FAIL mdu_stall_%0d: got %b want 101", i, {mdu_busy, if_id_ready, ex_flush}); end
            tick();
        end
        #1;
        n_checks++; if ({mdu_busy, if_id_ready, ex_flush} !== 3'b010) begin n_fail++; $display("FAIL mdu_done: got %b want 010", {mdu_busy, if_id_ready, ex_flush}); end
    endtask

    task automatic test_exception();
        tick();
        idle();
        id_rt = 8; id_use_rt = 1; ex_wen = 1; ex_rd = 8; ex_is_load = 1;
        exc_req = 1;
        #1;
        n_checks++; if ({if_id_ready, ex_ready, id_flush, ex_flush, mem_flush} !== 5'b11111) begin n_fail++; $display("FAIL exc_same_cycle: got %b want 11111", {if_id_ready, ex_ready, id_flush, ex_flush, mem_flush}); end
        tick();
        exc_req = 0;
        #1;
        n_checks++; if ({if_id_ready, id_flush, ex_flush, mem_flush} !== 4'b1111) begin n_fail++; $display("FAIL exc_flush_state: got %b want 1111", {if_id_ready, id_flush, ex_flush, mem_flush}); end
        tick();
        #1;
        n_checks++; if ({if_id_ready, id_flush, ex_flush, mem_flush} !== 4'b0010) begin n_fail++; $display("FAIL exc_back_run: got %b want 0010", {if_id_ready, id_flush, ex_flush, mem_flush}); end
        // second exc while in FLUSH restarts the hold
        idle();
        exc_req = 1;
        tick();
        #1;
        n_checks++; if (mem_flush !== 1'b1) begin n_fail++; $display("FAIL exc_restart_pulse: got %b want 1", mem_flush); end
        tick();
        exc_req = 0;
        #1;
        n_checks++; if ({id_flush, mem_flush} !== 2'b11) begin n_fail++; $display("FAIL exc_restart_hold: got %b want 11", {id_flush, mem_flush}); end
        tick();
        #1;
        n_checks++; if ({id_flush, ex_flush, mem_flush} !== 3'b000) begin n_fail++; $display("FAIL exc_restart_end: got %b want 000", {id_flush, ex_flush, mem_flush}); end
    endtask

    task automatic test_reset_mid();
        tick();
        idle();
        ex_mdu_start = 1;
        tick();
        ex_mdu_start = 0; exc_req = 1;
        tick();
        exc_req = 0;
        #1;
        n_checks++; if ({mdu_busy, mem_flush} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got %b want 11", {mdu_busy, mem_flush}); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if ({mdu_busy, id_flush, ex_flush, mem_flush, if_id_ready} !== 5'b00001) begin n_fail++; $display("FAIL mid_post: got %b want 00001", {mdu_busy, id_flush, ex_flush, mem_flush, if_id_ready}); end
        tick();
        #1;
        n_checks++; if ({mdu_busy, mem_flush} !== 2'b00) begin n_fail++; $display("FAIL mid_settled: got %b want 00", {mdu_busy, mem_flush}); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch_load();
        test_mdu();
        test_exception();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline scheduler for the 5-stage core. Generates per-stage READY/FLUSH strobes and the ID-stage rs/rt fast-forward selects and data consumed by the branch/jump unit in the decode stage. Handles load-use and branch-after-load stalls, multi-cycle MDU occupancy and exception/eret flush sequencing. Sits beside the pipeline and observes ID source registers plus EX/MEM destination buses.

Parameters:
DATA_W, 32, register data width
MDU_CYCLES, 32, cycles the multiply/divide unit stays busy after start (>=2)
EXC_FLUSH_CYCLES, 1, cycles all younger stages are held flushed after exception/eret

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_rs  in  5  ID rs index
id_rt  in  5  ID rt index
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction resolves a branch/jr in ID
id_mdu_use  in  1  ID is mult/div/mfhi/mflo/mthi/mtlo
ex_wen  in  1  EX instruction writes a GPR
ex_rd  in  5  EX destination
ex_is_load  in  1  EX is a load
ex_result  in  DATA_W  EX ALU result
ex_mdu_start  in  1  EX launches mult/div this cycle
mem_wen  in  1  MEM instruction writes a GPR
mem_rd  in  5  MEM destination
mem_is_load  in  1  MEM is a load (data not ready until WB)
mem_result  in  DATA_W  MEM forwarded result
exc_req  in  1  exception or eret taken (one-cycle pulse)
if_id_ready  out  1  PIPELINE_READY for IF and ID
ex_ready  out  1  PIPELINE_READY for EX/MEM/WB
id_flush  out  1  PIPELINE_FLUSH to ID
ex_flush  out  1  inject bubble into EX
mem_flush  out  1  inject bubble into MEM
s_rs_fastforward  out  1  rs forward valid
d_rs_fastforward  out  DATA_W  rs forward data
s_rt_fastforward  out  1  rt forward valid
d_rt_fastforward  out  DATA_W  rt forward data
mdu_busy  out  1  MDU occupied

Behaviour:
- Forwarding (combinational): for rs (rt identical): match if id_use_rs and index!=0. Priority EX (ex_wen, ex_rd match, !ex_is_load) -> ex_result; else MEM (mem_wen, mem_rd match, !mem_is_load) -> mem_result; else s_=0, d_=0.
- Hazard terms: load_use = ex_is_load & ex_wen & matching used source (index!=0). br_load = id_is_branch & mem_is_load & mem_wen & match. br_ex = id_is_branch & ex_wen & match & ex_is_load (covered by load_use). mdu_stall = id_mdu_use & mdu_busy.
- stall = load_use | br_load | mdu_stall. When stall: if_id_ready=0, ex_ready=1, ex_flush=1 (bubble), no ID flush.
- FSM states RUN, FLUSH (registered). RUN->FLUSH on exc_req; FLUSH holds EXC_FLUSH_CYCLES then ->RUN. In FLUSH or on the exc_req cycle: if_id_ready=1, ex_ready=1, id_flush=ex_flush=mem_flush=1; stall ignored. exc_req while already in FLUSH restarts the count.
- MDU counter: ex_mdu_start with ex_ready loads MDU_CYCLES-1; decrements to 0; mdu_busy = counter!=0. exc_req does not abort it. Start while busy reloads.
- Reset (rst_n=0 at clk edge): state RUN, counter 0. Outputs during/after reset: if_id_ready=1, ex_ready=1, all flush=0, forwards 0, mdu_busy=0. Reset mid-MDU clears busy next cycle.
- Latency: hazard/forward outputs combinational same cycle; FSM/counter effects from next edge.

Decomposition:
- Shared config header: stage index constants, FSM state encodings, MDU_CYCLES default.
- One sub-module: fwd_sel (source match + priority mux), instantiated twice for rs and rt.

Test Plan:
- EX add writes r5=0x1234, ID beq uses r5 -> s_rs_fastforward=1, d_rs_fastforward=0x1234, no stall.
- EX lw r8, ID add uses rt=r8 -> if_id_ready=0, ex_flush=1 one cycle; next cycle no EX match, stall cleared.
- MEM lw r3, ID bne uses r3 -> 1-cycle stall; r0 source with EX writing r0 -> no forward, no stall.
- ex_mdu_start, MDU_CYCLES=4, then mflo in ID -> stall exactly 3 cycles, mdu_busy deasserts, then ready.
- exc_req during load-use stall -> same cycle id/ex/mem_flush=1, if_id_ready=1; RUN after 1 cycle.
- rst_n low during MDU busy and FLUSH -> next cycle mdu_busy=0, state RUN, all flush=0.
